// File: rtl/pass_keeper_pkg.sv
// Shared definitions for the password checker: default sizes, FSM state
// encodings and the digit type used on the keypad and memory sides.
package pass_keeper_pkg;

  localparam int DEF_PASS_LEN = 4;
  localparam int DEF_MAX_FAIL = 3;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 4;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t WAIT_DIGIT = 3'd1;
  localparam state_t CS_HI      = 3'd2;
  localparam state_t SAMPLE     = 3'd3;
  localparam state_t DONE       = 3'd4;

  typedef logic [DEF_DATA_W-1:0] digit_t;

endpackage

// File: rtl/pass_checker_if.sv
// Keypad-side handshake, status outputs and password-memory read port of
// the checker. master = checker, slave = surrounding system.
interface pass_checker_if
  import pass_keeper_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PASS_LEN = DEF_PASS_LEN,
  parameter int MAX_FAIL = DEF_MAX_FAIL
);
  localparam int UID_W  = ADDR_W - $clog2(PASS_LEN);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);

  logic              start;
  logic [UID_W-1:0]  user_id;
  logic              abort;
  logic              digit_valid;
  logic [DATA_W-1:0] digit;
  logic              digit_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs;
  logic [DATA_W-1:0] mem_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic              locked;
  logic [FCNT_W-1:0] fail_cnt;

  modport master (
    input  start, user_id, abort, digit_valid, digit, mem_data,
    output digit_ready, mem_addr, mem_cs, busy, done, pass, locked, fail_cnt
  );

  modport slave (
    output start, user_id, abort, digit_valid, digit, mem_data,
    input  digit_ready, mem_addr, mem_cs, busy, done, pass, locked, fail_cnt
  );
endinterface

// File: rtl/pass_mem_reader.sv
// Strobe-and-capture read of the nibble memory: one-cycle registered CS per
// request, read data presented the following cycle with rvalid.
module pass_mem_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  logic              cs_p1;
  logic              vld_p2;
  logic [ADDR_W-1:0] addr_p0;

  // Address follows the requested next address every edge; CS stage then sample stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0 <= '0;
      cs_p1   <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      addr_p0 <= addr;
      // stage 1: CS high for exactly one cycle
      cs_p1   <= req;
      // stage 2: memory data settled, hand to caller
      vld_p2  <= cs_p1 && !flush;
    end
  end

  assign mem_cs   = cs_p1;
  assign mem_addr = addr_p0;
  assign rdata    = mem_data;
  assign rvalid   = vld_p2;

endmodule

// File: rtl/pass_checker.sv
// Password checker: fetches the stored digit for each entered digit, compares
// all positions without early exit, reports pass/fail and tracks lockout.
module pass_checker
  import pass_keeper_pkg::*;
#(
  parameter int PASS_LEN = DEF_PASS_LEN,
  parameter int MAX_FAIL = DEF_MAX_FAIL,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  pass_checker_if.master bus
);

  localparam int IDX_W  = $clog2(PASS_LEN);
  localparam int UID_W  = ADDR_W - IDX_W;
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PASS_LEN - 1);
  localparam logic [FCNT_W-1:0] FAIL_MAX = FCNT_W'(MAX_FAIL);

  state_t            state;
  logic [UID_W-1:0]  uid_q;
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              pass_q;
  logic [FCNT_W-1:0] fail_q;
  logic [DATA_W-1:0] digit_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              locked;
  logic              start_ok;
  logic              accept;
  logic              err_now;
  logic              rd_cs;
  logic [ADDR_W-1:0] rd_addr;

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    if (v >= FAIL_MAX) return v;
    return v + 1'b1;
  endfunction

  assign locked   = (fail_q == FAIL_MAX);
  assign start_ok = (state == IDLE) && bus.start && !locked && !bus.abort;
  assign accept   = (state == WAIT_DIGIT) && bus.digit_valid && !bus.abort;
  assign err_now  = err | (rdata != digit_q);

  // Next memory address: new slot on start, next index after a sample, else hold.
  always_comb begin
    addr_nxt = {uid_q, idx};
    if (start_ok)
      addr_nxt = {bus.user_id, IDX_W'(0)};
    else if ((state == SAMPLE) && !bus.abort && (idx != LAST_IDX))
      addr_nxt = {uid_q, IDX_W'(idx + 1'b1)};
  end

  pass_mem_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_reader (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.abort),
    .req      (accept),
    .addr     (addr_nxt),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .mem_cs   (rd_cs),
    .mem_addr (rd_addr),
    .mem_data (bus.mem_data)
  );

  // Attempt FSM with index, error accumulation and fail/lock counter; abort wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      uid_q  <= '0;
      idx    <= '0;
      err    <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= '0;
    end else if (bus.abort && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            uid_q  <= bus.user_id;
            idx    <= '0;
            err    <= 1'b0;
            pass_q <= 1'b0;
            state  <= WAIT_DIGIT;
          end
        end
        WAIT_DIGIT: if (bus.digit_valid) state <= CS_HI;
        CS_HI:      state <= SAMPLE;
        SAMPLE: begin
          if (rvalid) begin
            err <= err_now;
            if (idx == LAST_IDX) begin
              pass_q <= !err_now;
              fail_q <= err_now ? sat_inc(fail_q) : '0;
              state  <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= WAIT_DIGIT;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Entered digit held for the compare two cycles later.
  always_ff @(posedge clk) begin
    if (accept) digit_q <= bus.digit;
  end

  assign bus.digit_ready = (state == WAIT_DIGIT);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.pass        = pass_q;
  assign bus.locked      = locked;
  assign bus.fail_cnt    = fail_q;
  assign bus.mem_cs      = rd_cs;
  assign bus.mem_addr    = rd_addr;

endmodule

// File: doc/pass_checker.md
Name: pass_checker

Overview:
- Initiator-side controller for the password nibble memory (4-bit address, 4-bit data, CS-strobed read).
- Accepts a user slot select and a stream of entered digits, fetches the stored digit for each position over the memory read port, and compares the two.
- Reports pass/fail per attempt and maintains a failed-attempt counter with lockout.
- Sits between the keypad/digit front end and the password memory.

Parameters:
- PASS_LEN, 4, digits per code; must be a power of 2 and no greater than 2**ADDR_W.
- MAX_FAIL, 3, consecutive failed attempts before lockout.
- ADDR_W, 4, memory address width.
- DATA_W, 4, digit/memory data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin an attempt (sampled in IDLE only)
- user_id  in  ADDR_W-log2(PASS_LEN)  slot select, latched on start
- abort  in  1  cancel the current attempt
- digit_valid  in  1  entered digit present
- digit  in  DATA_W  entered digit value
- digit_ready  out  1  high only in WAIT_DIGIT; a digit is accepted when valid&&ready
- mem_addr  out  ADDR_W  {uid_q, idx}, registered
- mem_cs  out  1  read strobe; the memory captures on its rising edge
- mem_data  in  DATA_W  memory read data
- busy  out  1  high from start accept until return to IDLE
- done  out  1  one-cycle pulse at end of attempt
- pass  out  1  result of last attempt, held until next start
- locked  out  1  fail_cnt == MAX_FAIL
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Reset values (async, immediate): state=IDLE; mem_cs, mem_addr, busy, digit_ready, done, pass, locked, fail_cnt all 0.
- States:
  - IDLE: on start && !locked && !abort: latch user_id, idx=0, err=0, pass=0, busy=1, go to WAIT_DIGIT. Otherwise remain.
  - WAIT_DIGIT: on digit_valid: latch digit, go to CS_HI. A registered mem_cs rises after this edge (edge N). mem_addr is already stable from the previous cycle.
  - CS_HI: one cycle, mem_cs=1. Go to SAMPLE; mem_cs drops after edge N+1.
  - SAMPLE: at edge N+2, err |= (mem_data != digit_q).
    - If idx == PASS_LEN-1, go to DONE.
    - Else idx++ and go to WAIT_DIGIT.
  - DONE: one cycle.
    - done=1, pass=!err, busy drops on exit, go to IDLE.
    - On pass, fail_cnt=0.
    - On fail, fail_cnt++ saturating at MAX_FAIL.
- Per-digit latency: accept to compare is 2 cycles. digit_ready reasserts on the cycle after SAMPLE. Last accept to done pulse is 3 cycles.
- mem_cs is high for exactly one cycle per digit. mem_addr never changes while mem_cs=1 or in SAMPLE.
- A mismatch does not terminate early. All PASS_LEN digits are always consumed, so timing reveals nothing.
- abort in any state other than IDLE: next edge goes to IDLE. mem_cs=0, busy=0, no done pulse, fail_cnt and pass unchanged. abort has priority over digit_valid and sample.
- start while busy: ignored. start while locked: ignored, no done pulse.
- digit_valid outside WAIT_DIGIT: ignored. The digit is not queued.
- locked clears only by rst. Reset mid-attempt discards everything.
- idx width is log2(PASS_LEN). Address = {uid_q, idx}, with no wrap across slots.

Decomposition:
- Package pass_keeper_pkg: state enum (IDLE, WAIT_DIGIT, CS_HI, SAMPLE, DONE), default PASS_LEN/MAX_FAIL/ADDR_W/DATA_W constants, and the shared digit type.
- Natural sub-module: pass_mem_reader, the CS_HI/SAMPLE strobe-and-capture handshake. Its interface is req/addr in, rdata/rvalid out, and it is reusable by a future programming block.
- The top FSM keeps idx, err, and fail/lock.

Test Plan:
- Bench memory model: slot0 = 5,F,1,A; slot1 = 1,7,1,6; slot2 = 1,9,D,8; slot3 = A,B,C,B.
- Correct code: start uid=0, digits 5,F,1,A.
  - mem_addr 0,1,2,3 with one-cycle mem_cs each.
  - done pulse 3 cycles after the last accept, pass=1, fail_cnt=0.
- Wrong digit: uid=2, digits 1,9,C,8.
  - All 4 digits are still consumed.
  - done with pass=0, fail_cnt=1.
- Lockout: three failing attempts on uid=3 give fail_cnt=3 and locked=1.
  - A subsequent start is ignored: busy stays 0, no done.
  - rst clears locked and fail_cnt to 0.
- Abort: uid=1, digits 1,7, then abort in WAIT_DIGIT.
  - Next cycle: IDLE, busy=0, no done, fail_cnt unchanged.
  - A new attempt 1,7,1,6 passes.
- Handshake and reset:
  - digit_valid held high continuously: exactly one digit is accepted every 3 cycles.
  - digit_valid pulsed during CS_HI: ignored.
  - Async rst asserted while mem_cs=1: mem_cs, busy, and state go to 0/IDLE immediately.
